// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: takes a length-prefixed byte stream,
// packs it into little-endian 32-bit words and keeps the CPU in reset until done.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic [1:0]       lane;
    logic [23:0]      asm_word;

    logic             accept;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] idx_next;

    // Ready decode of the byte-consuming states.
    always_comb begin
        byte_ready = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA: byte_ready = 1'b1;
            default:                    byte_ready = 1'b0;
        endcase
    end

    assign accept   = byte_valid && byte_ready;
    assign len_full = LEN_W'({byte_data, len[7:0]});
    assign idx_next = idx + ONE_L;

    // Load sequencer with registered status and write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len      <= '0;
            idx      <= '0;
            lane     <= 2'd0;
            asm_word <= 24'd0;
            we       <= 1'b0;
            wa       <= 32'd0;
            wd       <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN_LO;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        idx      <= '0;
                        lane     <= 2'd0;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len   <= LEN_W'(byte_data);
                        state <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len <= len_full;
                        if (len_full == '0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
                        end else if (len_full > DEPTH_L) begin
                            // Oversized image: refuse it before any word is written.
                            state <= S_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                            lane  <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: asm_word[7:0]   <= byte_data;
                            2'd1: asm_word[15:8]  <= byte_data;
                            2'd2: asm_word[23:16] <= byte_data;
                            default: begin
                                state <= S_WRITE;
                                we    <= 1'b1;
                                wa    <= 32'({idx, 2'b00});
                                wd    <= {byte_data, asm_word};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    idx <= idx_next;
                    if (idx_next == len) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= S_DATA;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are sent
// and checked when the loader pulses we.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int n_checks = 0;
    int n_fail   = 0;
    int n_we     = 0;
    logic [63:0] exp_q[$];

    imem_loader #(.DEPTH(64), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .we(we), .wa(wa), .wd(wd),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: every we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            logic [63:0] e;
            n_we++;
            n_checks++;
            if (byte_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL write_ready: byte_ready=%b during write, expected 0", byte_ready);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: wa=%h wd=%h with empty scoreboard", wa, wd);
            end else begin
                e = exp_q.pop_front();
                if ({wa, wd} !== e) begin
                    n_fail++;
                    $display("FAIL write_data: wa=%h wd=%h expected wa=%h wd=%h",
                             wa, wd, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int c;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        c = 0;
        while (byte_ready !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (c >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: byte_ready=%b expected 1 within 50 cycles", byte_ready);
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int maxgap);
        exp_q.push_back({addr, w});
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!(done === 1'b1 || err === 1'b1) && c < 200) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c >= 200) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%b err=%b expected completion", name, done, err);
        end
    endtask

    task automatic check_status(input string name, input logic e_busy, input logic e_done,
                                input logic e_err, input logic e_hold);
        n_checks++;
        if ({busy, done, err, cpu_hold} !== {e_busy, e_done, e_err, e_hold}) begin
            n_fail++;
            $display("FAIL %s: busy/done/err/hold=%b%b%b%b expected %b%b%b%b", name,
                     busy, done, err, cpu_hold, e_busy, e_done, e_err, e_hold);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({byte_ready, we, wa, wd, busy, done, err, cpu_hold} !==
            {1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s: rdy=%b we=%b wa=%h wd=%h busy=%b done=%b err=%b hold=%b expected reset values",
                     name, byte_ready, we, wa, wd, busy, done, err, cpu_hold);
        end
    endtask

    task automatic check_queue_empty(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d writes missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_basic();
        int we0 = n_we;
        pulse_start();
        check_status("basic_start", 1'b1, 1'b0, 1'b0, 1'b1);
        send_header(16'd2);
        send_word(32'h0010_0513, 32'h0, 0);
        send_word(32'h0020_0593, 32'h4, 0);
        wait_done("basic");
        check_status("basic_done", 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (n_we - we0 != 2) begin
            n_fail++;
            $display("FAIL basic_count: %0d writes, expected 2", n_we - we0);
        end
        check_queue_empty("basic");
    endtask

    task automatic test_zero();
        int we0 = n_we;
        pulse_start();
        send_header(16'd0);
        repeat (2) @(negedge clk);
        check_status("zero_done", 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (n_we != we0) begin
            n_fail++;
            $display("FAIL zero_writes: %0d writes, expected 0", n_we - we0);
        end
    endtask

    task automatic test_too_long();
        int we0 = n_we;
        pulse_start();
        send_header(16'd65);
        repeat (2) @(negedge clk);
        check_status("len_err", 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (n_we != we0) begin
            n_fail++;
            $display("FAIL err_writes: %0d writes, expected 0", n_we - we0);
        end
        pulse_start();
        check_status("err_cleared", 1'b1, 1'b0, 1'b0, 1'b1);
        send_header(16'd1);
        send_word(32'hDEAD_BEEF, 32'h0, 0);
        wait_done("after_err");
        check_status("after_err_done", 1'b0, 1'b1, 1'b0, 1'b0);
        check_queue_empty("after_err");
    endtask

    task automatic test_random_gaps();
        int we0 = n_we;
        pulse_start();
        send_header(16'd3);
        for (int i = 0; i < 3; i++)
            send_word($urandom(), 32'(i * 4), 3);
        wait_done("gaps");
        check_status("gaps_done", 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (n_we - we0 != 3) begin
            n_fail++;
            $display("FAIL gaps_count: %0d writes, expected 3", n_we - we0);
        end
        check_queue_empty("gaps");
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_header(16'd4);
        send_word(32'h1122_3344, 32'h0, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_reset_outputs("reset_no_partial");
        check_queue_empty("reset_mid");
        pulse_start();
        send_header(16'd1);
        send_word(32'hCAFE_F00D, 32'h0, 0);
        wait_done("after_reset");
        check_status("after_reset_done", 1'b0, 1'b1, 1'b0, 1'b0);
        check_queue_empty("after_reset");
    endtask

    task automatic test_start_in_data();
        pulse_start();
        send_header(16'd2);
        exp_q.push_back({32'h0, 32'h0403_0201});
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        pulse_start();
        check_status("start_ignored", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_word(32'h0807_0605, 32'h4, 1);
        wait_done("start_in_data");
        check_status("start_in_data_done", 1'b0, 1'b1, 1'b0, 1'b0);
        check_queue_empty("start_in_data");
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        test_reset();
        test_basic();
        test_zero();
        test_too_long();
        test_random_gaps();
        test_reset_mid();
        test_start_in_data();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
